// File: rtl/sw_pkg.sv
// sw_pkg: shared constants, FSM states and base encoding for the systolic alignment sequencer
package sw_pkg;
   localparam int N_PE = 64;
   localparam int LEN_A = 1024;
   localparam int LEN_B = 1024;
   localparam int SCORE_W = 12;
   localparam int N_SEG = LEN_B / N_PE;
   typedef enum logic [1:0] {IDLE, LOAD_B, STREAM, DRAIN} state_t;
   typedef enum logic [1:0] {BASE_A, BASE_C, BASE_G, BASE_T} base_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sw_array_ctrl_if.sv
// sw_array_ctrl_if: gene SRAM read ports and PE array stream between the sequencer and its neighbours
interface sw_array_ctrl_if
   import sw_pkg::*;
#(
   parameter int P_N_PE = N_PE,
   parameter int P_LEN_A = LEN_A,
   parameter int P_LEN_B = LEN_B,
   parameter int P_SCORE_W = SCORE_W
);
   localparam int A_W = idx_w(P_LEN_A);
   localparam int SEG_W = idx_w(P_LEN_B / P_N_PE);
   logic [A_W-1:0] o_A_addr;
   logic [1:0] i_A_data;
   logic [SEG_W-1:0] o_B_addr;
   logic [2*P_N_PE-1:0] i_B_data;
   logic o_pe_clr;
   logic o_pe_start;
   logic [1:0] o_pe_A;
   logic [2*P_N_PE-1:0] o_pe_B;
   logic [P_SCORE_W-1:0] o_pe_H_left;
   logic [P_SCORE_W-1:0] i_pe_H_last;
   logic i_pe_H_valid;
   modport master (
      output o_A_addr, o_B_addr, o_pe_clr, o_pe_start, o_pe_A, o_pe_B, o_pe_H_left,
      input i_A_data, i_B_data, i_pe_H_last, i_pe_H_valid
   );
   modport slave (
      input o_A_addr, o_B_addr, o_pe_clr, o_pe_start, o_pe_A, o_pe_B, o_pe_H_left,
      output i_A_data, i_B_data, i_pe_H_last, i_pe_H_valid
   );
endinterface

// File: rtl/sw_bound_buf.sv
// sw_bound_buf: boundary score buffer, one write and one registered read per cycle (read-before-write)
module sw_bound_buf
   import sw_pkg::*;
#(
   parameter int P_DEPTH = LEN_A,
   parameter int P_W = SCORE_W
)(
   input  logic                      i_clk,
   input  logic                      i_we,
   input  logic [idx_w(P_DEPTH)-1:0] i_waddr,
   input  logic [P_W-1:0]            i_wdata,
   input  logic                      i_re,
   input  logic [idx_w(P_DEPTH)-1:0] i_raddr,
   output logic [P_W-1:0]            o_rdata
);
   logic [P_W-1:0] r_mem [P_DEPTH];
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/sw_array_ctrl.sv
// sw_array_ctrl: segment sequencer feeding gene bases and left-boundary scores into the systolic PE array,
// capturing the last column of each segment as the next segment's left boundary.
module sw_array_ctrl
   import sw_pkg::*;
#(
   parameter int P_N_PE = N_PE,
   parameter int P_LEN_A = LEN_A,
   parameter int P_LEN_B = LEN_B,
   parameter int P_SCORE_W = SCORE_W
)(
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_start,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic [idx_w(P_LEN_B / P_N_PE)-1:0]   o_seg,
   output logic                                 o_err,
   sw_array_ctrl_if.master                      bus
);
   localparam int N_SEG_L = P_LEN_B / P_N_PE;
   localparam int A_W = idx_w(P_LEN_A);
   localparam int SEG_W = idx_w(N_SEG_L);
   localparam int WR_W = idx_w(P_LEN_A + 1);
   state_t r_state;
   logic [A_W-1:0] r_t;
   logic [WR_W-1:0] r_wr_idx;
   logic [SEG_W-1:0] r_seg;
   logic [2*P_N_PE-1:0] r_pe_B;
   logic r_pe_start;
   logic r_b_load;
   logic r_err;
   logic [P_SCORE_W-1:0] w_rdata;
   logic w_full;
   logic w_last;
   logic w_we;
   logic w_drop;
   assign w_full = r_wr_idx == WR_W'(P_LEN_A);
   assign w_last = r_seg == SEG_W'(N_SEG_L - 1);
   assign w_we = bus.i_pe_H_valid && !w_full && (r_state == STREAM || r_state == DRAIN);
   assign w_drop = bus.i_pe_H_valid && !w_we;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_t <= '0;
         r_wr_idx <= '0;
         r_seg <= '0;
         r_pe_B <= '0;
         r_pe_start <= 1'b0;
         r_b_load <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_pe_start <= r_state == STREAM;
         r_b_load <= r_state == LOAD_B;
         if (r_b_load) r_pe_B <= bus.i_B_data;
         if (w_we) r_wr_idx <= r_wr_idx + 1'b1;
         if (w_drop) r_err <= 1'b1;
         case (r_state)
            IDLE: if (i_start) begin
               r_state <= LOAD_B;
               r_seg <= '0;
               r_err <= w_drop;
            end
            LOAD_B: begin
               r_state <= STREAM;
               r_t <= '0;
               r_wr_idx <= '0;
            end
            STREAM: begin
               r_t <= r_t + 1'b1;
               if (r_t == A_W'(P_LEN_A - 1)) begin
                  r_state <= DRAIN;
                  r_t <= '0;
               end
            end
            DRAIN: if (w_full) begin
               r_state <= w_last ? IDLE : LOAD_B;
               if (!w_last) r_seg <= r_seg + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   sw_bound_buf #(.P_DEPTH(P_LEN_A), .P_W(P_SCORE_W)) u_buf (
      .i_clk  (i_clk),
      .i_we   (w_we),
      .i_waddr(r_wr_idx[A_W-1:0]),
      .i_wdata(bus.i_pe_H_last),
      .i_re   (r_state == STREAM),
      .i_raddr(r_t),
      .o_rdata(w_rdata)
   );
   // segment 0 has no left neighbour, so its boundary is forced to zero
   assign bus.o_pe_H_left = (r_pe_start && r_seg != '0) ? w_rdata : '0;
   assign bus.o_pe_A = r_pe_start ? bus.i_A_data : 2'b00;
   assign bus.o_pe_B = r_pe_B;
   assign bus.o_pe_start = r_pe_start;
   assign bus.o_pe_clr = r_state == LOAD_B;
   assign bus.o_A_addr = r_t;
   assign bus.o_B_addr = r_seg;
   assign o_busy = r_state != IDLE;
   assign o_done = r_state == DRAIN && w_full && w_last;
   assign o_seg = r_seg;
   assign o_err = r_err;
endmodule

// File: tb/tb_sw_array_ctrl.sv
// tb_sw_array_ctrl: directed run of the sequencer against SRAM and PE-array models,
// every o_pe_start beat checked against a queue of expected base/boundary/segment values.
module tb_sw_array_ctrl;
   import sw_pkg::*;
   localparam int TN = 4;
   localparam int TA = 8;
   localparam int TB = 8;
   localparam int TS = 12;
   typedef struct packed {
      logic [2:0] addr;
      logic [1:0] a;
      logic [TS-1:0] h;
      logic [2*TN-1:0] b;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic inj = 1'b0;
   logic busy, done, err, seg;
   logic [1:0] amem [TA];
   logic [2*TN-1:0] bmem [2];
   logic [3:0] sr;
   int jcnt = 0;
   logic prev_last = 1'b0;
   logic [2:0] prev_addr = '0;
   exp_t q[$];
   int bq[$];
   int done_cnt = 0;
   int n_assert = 0;
   int n_fail = 0;
   sw_array_ctrl_if #(.P_N_PE(TN), .P_LEN_A(TA), .P_LEN_B(TB), .P_SCORE_W(TS)) bus ();
   sw_array_ctrl #(.P_N_PE(TN), .P_LEN_A(TA), .P_LEN_B(TB), .P_SCORE_W(TS)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_start(start),
      .o_busy (busy),
      .o_done (done),
      .o_seg  (seg),
      .o_err  (err),
      .bus    (bus)
   );
   always #5 clk = ~clk;
   // SRAMs with one-cycle read latency and an array that answers four cycles after each start
   always @(posedge clk) begin
      bus.i_A_data <= amem[bus.o_A_addr];
      bus.i_B_data <= bmem[bus.o_B_addr];
      sr <= rst ? 4'b0 : {sr[2:0], bus.o_pe_start};
      jcnt <= (rst || bus.o_pe_clr) ? 0 : jcnt + int'(sr[3]);
   end
   assign bus.i_pe_H_valid = sr[3] | inj;
   assign bus.i_pe_H_last = inj ? TS'(99) : TS'((seg ? 20 : 10) + jcnt);
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.o_pe_clr) begin
            if (bq.size() == 0) check("b_addr_extra", 1, 0);
            else check("b_addr", 32'(bus.o_B_addr), bq.pop_front());
         end
         if (bus.o_pe_start) begin
            if (q.size() == 0) check("pe_start_extra", 1, 0);
            else begin
               e = q.pop_front();
               check("a_addr", 32'(prev_addr), 32'(e.addr));
               check("pe_A", 32'(bus.o_pe_A), 32'(e.a));
               check("H_left", 32'(bus.o_pe_H_left), 32'(e.h));
               check("pe_B", 32'(bus.o_pe_B), 32'(e.b));
            end
         end
         if (done || prev_last) check("done_timing", 32'(done), 32'(prev_last));
         if (done) done_cnt++;
      end
      prev_addr = bus.o_A_addr;
      prev_last = sr[3] && jcnt == TA - 1 && seg;
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic push_run();
      for (int s = 0; s < 2; s++) begin
         bq.push_back(s);
         for (int t = 0; t < TA; t++)
            q.push_back(exp_t'{addr: 3'(t), a: amem[t], h: TS'(s != 0 ? 10 + t : 0), b: bmem[s]});
      end
   endtask
   task automatic wait_done(input string tag);
      for (int i = 0; i < 300 && !done; i++) @(negedge clk);
      check(tag, 32'(done), 1);
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_seg"}, 32'(seg), 0);
      check({tag, "_A_addr"}, 32'(bus.o_A_addr), 0);
      check({tag, "_B_addr"}, 32'(bus.o_B_addr), 0);
      check({tag, "_clr"}, 32'(bus.o_pe_clr), 0);
      check({tag, "_start"}, 32'(bus.o_pe_start), 0);
      check({tag, "_pe_A"}, 32'(bus.o_pe_A), 0);
      check({tag, "_pe_B"}, 32'(bus.o_pe_B), 0);
      check({tag, "_H_left"}, 32'(bus.o_pe_H_left), 0);
   endtask
   initial begin
      for (int i = 0; i < TA; i++) amem[i] = base_t'($urandom_range(0, 3));
      bmem[0] = 8'hB4;
      bmem[1] = 8'h1E;
      start = 1'b1;
      cyc(2);
      check_zero("rst");
      rst = 1'b0;
      start = 1'b0;
      cyc(1);
      check("idle_after_rst_start", 32'(busy), 0);
      push_run();
      pulse_start();
      check("busy_load", 32'(busy), 1);
      check("clr_load", 32'(bus.o_pe_clr), 1);
      cyc(4);
      pulse_start();
      cyc(5);
      check("busy_drain", 32'(busy), 1);
      pulse_start();
      wait_done("done_run1");
      cyc(3);
      check("single_done", 32'(done_cnt), 1);
      check("idle_run1", 32'(busy), 0);
      check("q_empty_run1", 32'(q.size()), 0);
      check("err_run1", 32'(err), 0);
      push_run();
      pulse_start();
      for (int i = 0; i < 300 && !(bus.o_pe_clr && seg); i++) @(negedge clk);
      check("reach_seg1", 32'(bus.o_pe_clr && seg), 1);
      cyc(4);
      rst = 1'b1;
      cyc(1);
      check_zero("mid_rst");
      rst = 1'b0;
      q.delete();
      bq.delete();
      cyc(1);
      push_run();
      pulse_start();
      check("err_fresh", 32'(err), 0);
      for (int i = 0; i < 300 && !(jcnt == TA && !seg); i++) @(negedge clk);
      check("seg0_drained", 32'(jcnt), TA);
      inj = 1'b1;
      cyc(1);
      inj = 1'b0;
      cyc(1);
      check("err_drain", 32'(err), 1);
      wait_done("done_run3");
      check("err_sticky", 32'(err), 1);
      cyc(2);
      inj = 1'b1;
      cyc(1);
      inj = 1'b0;
      cyc(1);
      check("err_idle", 32'(err), 1);
      check("q_empty_run3", 32'(q.size()), 0);
      push_run();
      pulse_start();
      check("err_cleared", 32'(err), 0);
      wait_done("done_run4");
      cyc(2);
      check("q_empty_run4", 32'(q.size()), 0);
      check("err_run4", 32'(err), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
